// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: bus layouts, ALU op codes and divider states.
package ex_stage_pkg;

    localparam int EX_BUS_W = 111;
    localparam int RF_BUS_W = 39;
    localparam int DIV_ITER = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_AND   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_XOR   = 4'd6,
        ALU_NOR   = 4'd7,
        ALU_SLL   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_SRA   = 4'd10,
        ALU_PASS2 = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic        div_en;
        logic        div_signed;
        logic        div_rem;
        logic        mem_re;
        logic        mem_we;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] st_data;
    } ex_bus_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX/MEM handshake and data SRAM request signals around the execute stage.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic                ID_EX_valid;
    logic [31:0]         ID_pc;
    logic [EX_BUS_W-1:0] ID_ex_bus;
    logic                MEM_allowin;
    logic                EX_allowin;
    logic                EX_MEM_valid;
    logic [31:0]         EX_pc;
    logic [RF_BUS_W-1:0] EX_rf_bus;
    logic                data_sram_en;
    logic [3:0]          data_sram_we;
    logic [31:0]         data_sram_addr;
    logic [31:0]         data_sram_wdata;

    modport slave (
        input  ID_EX_valid, ID_pc, ID_ex_bus, MEM_allowin,
        output EX_allowin, EX_MEM_valid, EX_pc, EX_rf_bus,
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

    modport master (
        output ID_EX_valid, ID_pc, ID_ex_bus, MEM_allowin,
        input  EX_allowin, EX_MEM_valid, EX_pc, EX_rf_bus,
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

endinterface

// File: rtl/ex_stage_divider.sv
// 32-iteration restoring divider on operand magnitudes; signs are reapplied on the way out.
module ex_divider
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        ack_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    div_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q, quo_q, dsr_q;
    logic        neg_q_q, neg_r_q, dz_q;

    logic        a_neg, b_neg, fits;
    logic [31:0] a_mag, b_mag, rem_step;
    logic [32:0] partial, diff;

    assign a_neg = signed_i & dividend_i[31];
    assign b_neg = signed_i & divisor_i[31];
    assign a_mag = a_neg ? -dividend_i : dividend_i;
    assign b_mag = b_neg ? -divisor_i : divisor_i;

    // quo_q doubles as the dividend shift register; quotient bits enter at the bottom
    assign partial  = {rem_q, quo_q[31]};
    assign diff     = partial - {1'b0, dsr_q};
    assign fits     = partial >= {1'b0, dsr_q};
    assign rem_step = fits ? diff[31:0] : partial[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        rem_q   <= '0;
                        quo_q   <= a_mag;
                        dsr_q   <= b_mag;
                        neg_q_q <= a_neg ^ b_neg;
                        neg_r_q <= a_neg;
                        dz_q    <= (divisor_i == 32'd0);
                        cnt_q   <= '0;
                        state_q <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    rem_q <= rem_step;
                    quo_q <= {quo_q[30:0], fits};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(DIV_ITER - 1)) begin
                        state_q <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (ack_i) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q == DIV_BUSY);
    assign done_o      = (state_q == DIV_DONE);
    assign quotient_o  = dz_q ? 32'hFFFF_FFFF : (neg_q_q ? -quo_q : quo_q);
    assign remainder_o = neg_r_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: pipeline register, inline ALU, iterative divider and data SRAM request.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    ex_stage_if.slave ex_if
);

    logic        ex_valid_q, ex_valid_d;
    logic [31:0] ex_pc_q, ex_pc_d;
    ex_bus_t     ex_bus_q, ex_bus_d;

    logic        ex_allowin, ex_ready_go;
    logic        div_start, div_busy, div_done;
    logic [31:0] div_quo, div_rem, alu_res, ex_result;
    logic [4:0]  shamt;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_bus_d   = ex_bus_q;
        if (ex_allowin) begin
            ex_valid_d = ex_if.ID_EX_valid;
            if (ex_if.ID_EX_valid) begin
                ex_pc_d  = ex_if.ID_pc;
                ex_bus_d = ex_bus_t'(ex_if.ID_ex_bus);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_bus_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_bus_q   <= ex_bus_d;
        end
    end

    assign shamt = ex_bus_q.src2[4:0];

    always_comb begin
        alu_res = '0;
        case (ex_bus_q.alu_op)
            ALU_ADD:   alu_res = ex_bus_q.src1 + ex_bus_q.src2;
            ALU_SUB:   alu_res = ex_bus_q.src1 - ex_bus_q.src2;
            ALU_SLT:   alu_res = {31'd0, $signed(ex_bus_q.src1) < $signed(ex_bus_q.src2)};
            ALU_SLTU:  alu_res = {31'd0, ex_bus_q.src1 < ex_bus_q.src2};
            ALU_AND:   alu_res = ex_bus_q.src1 & ex_bus_q.src2;
            ALU_OR:    alu_res = ex_bus_q.src1 | ex_bus_q.src2;
            ALU_XOR:   alu_res = ex_bus_q.src1 ^ ex_bus_q.src2;
            ALU_NOR:   alu_res = ~(ex_bus_q.src1 | ex_bus_q.src2);
            ALU_SLL:   alu_res = ex_bus_q.src1 << shamt;
            ALU_SRL:   alu_res = ex_bus_q.src1 >> shamt;
            ALU_SRA:   alu_res = 32'($signed(ex_bus_q.src1) >>> shamt);
            ALU_PASS2: alu_res = ex_bus_q.src2;
            default:   alu_res = '0;
        endcase
    end

    // Only kick the divider from IDLE; a finished result waits in DONE until handoff
    assign div_start = ex_valid_q & ex_bus_q.div_en & ~div_busy & ~div_done;

    ex_divider u_div (
        .clk         (clk),
        .rst         (reset),
        .start_i     (div_start),
        .ack_i       (ex_allowin),
        .signed_i    (ex_bus_q.div_signed),
        .dividend_i  (ex_bus_q.src1),
        .divisor_i   (ex_bus_q.src2),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign ex_ready_go = ~ex_bus_q.div_en | div_done;
    assign ex_allowin  = ~ex_valid_q | (ex_ready_go & ex_if.MEM_allowin);
    assign ex_result   = ex_bus_q.div_en ? (ex_bus_q.div_rem ? div_rem : div_quo) : alu_res;

    assign ex_if.EX_allowin      = ex_allowin;
    assign ex_if.EX_MEM_valid    = ex_valid_q & ex_ready_go;
    assign ex_if.EX_pc           = ex_pc_q;
    assign ex_if.EX_rf_bus       = {ex_bus_q.mem_re, ex_bus_q.rf_we & ex_valid_q,
                                    ex_bus_q.rf_waddr, ex_result};
    assign ex_if.data_sram_en    = ex_valid_q & ex_ready_go & ex_if.MEM_allowin &
                                   (ex_bus_q.mem_re | ex_bus_q.mem_we);
    assign ex_if.data_sram_we    = {4{ex_bus_q.mem_we & ex_if.data_sram_en}};
    assign ex_if.data_sram_addr  = alu_res;
    assign ex_if.data_sram_wdata = ex_bus_q.st_data;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against a latency/arithmetic reference model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    ex_stage_if ifc();

    ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .ex_if (ifc.slave)
    );

    always #5 clk = ~clk;

    // Reference model: one instruction slot plus its age in cycles since entry
    logic        m_valid;
    logic [31:0] m_pc;
    ex_bus_t     m_bus;
    int          m_age;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return ~(a | b);
            4'd8:    return a << b[4:0];
            4'd9:    return a >> b[4:0];
            4'd10:   return 32'(sa >>> b[4:0]);
            4'd11:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn, input logic rem);
        logic [31:0] q, r;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return rem ? r : q;
    endfunction

    function automatic logic [110:0] mk(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                        input logic de, input logic ds, input logic dr,
                                        input logic re, input logic we, input logic rfwe,
                                        input logic [4:0] wa, input logic [31:0] sd);
        ex_bus_t b;
        b.alu_op = op; b.src1 = s1; b.src2 = s2;
        b.div_en = de; b.div_signed = ds; b.div_rem = dr;
        b.mem_re = re; b.mem_we = we; b.rf_we = rfwe;
        b.rf_waddr = wa; b.st_data = sd;
        return b;
    endfunction

    function automatic logic [110:0] mk_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic rem);
        return mk(4'd0, a, b, 1'b1, sgn, rem, 1'b0, 1'b0, 1'b1, 5'd9, 32'd0);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = '0;
        m_bus   = '0;
        m_age   = 0;
    endtask

    task automatic compare_and_advance();
        logic        ready, e_allow, e_mv, e_en;
        logic [31:0] alu, res;
        alu     = alu_model(m_bus.alu_op, m_bus.src1, m_bus.src2);
        res     = m_bus.div_en ? div_model(m_bus.src1, m_bus.src2, m_bus.div_signed, m_bus.div_rem) : alu;
        ready   = !m_bus.div_en || (m_age >= 33);
        e_allow = !m_valid || (ready && ifc.MEM_allowin);
        e_mv    = m_valid && ready;
        e_en    = e_mv && ifc.MEM_allowin && (m_bus.mem_re || m_bus.mem_we);
        check("allowin", 64'(ifc.EX_allowin), 64'(e_allow));
        check("mem_valid", 64'(ifc.EX_MEM_valid), 64'(e_mv));
        check("sram_en", 64'(ifc.data_sram_en), 64'(e_en));
        check("sram_we", 64'(ifc.data_sram_we), 64'({4{e_en && m_bus.mem_we}}));
        if (m_valid) check("ex_pc", 64'(ifc.EX_pc), 64'(m_pc));
        if (e_mv) check("rf_bus", 64'(ifc.EX_rf_bus),
                        64'({m_bus.mem_re, m_bus.rf_we, m_bus.rf_waddr, res}));
        if (e_en) begin
            check("sram_addr", 64'(ifc.data_sram_addr), 64'(alu));
            check("sram_wdata", 64'(ifc.data_sram_wdata), 64'(m_bus.st_data));
        end
        if (e_allow && ifc.ID_EX_valid) begin
            m_bus = ex_bus_t'(ifc.ID_ex_bus);
            m_pc  = ifc.ID_pc;
            m_age = 0;
        end else if (m_age < 1000) begin
            m_age++;
        end
        if (e_allow) m_valid = ifc.ID_EX_valid;
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [110:0] bus, input logic mem);
        @(posedge clk);
        #1;
        ifc.ID_EX_valid = v;
        ifc.ID_pc       = pc;
        ifc.ID_ex_bus   = bus;
        ifc.MEM_allowin = mem;
        @(negedge clk);
        compare_and_advance();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mv"}, 64'(ifc.EX_MEM_valid), 64'd0);
        check({tag, "_en"}, 64'(ifc.data_sram_en), 64'd0);
        check({tag, "_we"}, 64'(ifc.data_sram_we), 64'd0);
        check({tag, "_rf"}, 64'(ifc.EX_rf_bus), 64'd0);
        check({tag, "_pc"}, 64'(ifc.EX_pc), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        ifc.ID_EX_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_zero_outputs(tag);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input logic rem,
                           output int lat, output logic [31:0] res);
        lat = -1;
        res = '0;
        step(1'b1, 32'h200, mk_div(a, b, sgn, rem), 1'b1);
        for (int n = 0; n < 60; n++) begin
            step(1'b0, 32'h0, '0, 1'b1);
            if (ifc.EX_MEM_valid) begin
                lat = n;
                res = ifc.EX_rf_bus[31:0];
                break;
            end
        end
    endtask

    function automatic logic [110:0] rand_instr();
        logic [31:0] a, b;
        int kind;
        kind = $urandom_range(0, 9);
        a = $urandom;
        b = $urandom;
        case (kind)
            0, 1: begin
                case ($urandom_range(0, 4))
                    0: b = 32'd0;
                    1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    2: b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
                    default: ;
                endcase
                return mk_div(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            2: return mk(4'd0, a, 32'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                         5'($urandom_range(0, 31)), 32'd0);
            3: return mk(4'd0, a, 32'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                         5'd0, $urandom);
            default: return mk(4'($urandom_range(0, 15)), a, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 32'd0);
        endcase
    endfunction

    initial begin
        int          lat, en_cnt;
        logic [31:0] res;
        ifc.ID_EX_valid = 1'b0;
        ifc.ID_pc       = '0;
        ifc.ID_ex_bus   = '0;
        ifc.MEM_allowin = 1'b0;
        model_reset();
        #2;
        do_reset("por");
        check("por_allowin", 64'(ifc.EX_allowin), 64'd1);

        // ADD overflow wraps, handed off the next cycle for exactly one cycle
        step(1'b1, 32'h100, mk(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               5'd3, 32'd0), 1'b1);
        step(1'b0, 32'h0, '0, 1'b1);
        check("add_res", 64'(ifc.EX_rf_bus[31:0]), 64'h8000_0000);
        check("add_mv", 64'(ifc.EX_MEM_valid), 64'd1);
        step(1'b0, 32'h0, '0, 1'b1);
        check("add_mv_drop", 64'(ifc.EX_MEM_valid), 64'd0);

        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, lat, res);
        check("sdiv_lat", 64'(lat), 64'd33);
        check("sdiv_q", 64'(res), 64'hFFFF_FFFD);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, lat, res);
        check("sdiv_r", 64'(res), 64'hFFFF_FFFF);
        run_div(32'd100, 32'd0, 1'b0, 1'b0, lat, res);
        check("div0_q", 64'(res), 64'hFFFF_FFFF);
        run_div(32'd100, 32'd0, 1'b0, 1'b1, lat, res);
        check("div0_r", 64'(res), 64'd100);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat, res);
        check("ovf_q", 64'(res), 64'h8000_0000);

        // Store stalled by MEM for three cycles issues one request on release
        en_cnt = 0;
        step(1'b1, 32'h300, mk(4'd0, 32'h1000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                               5'd0, 32'hA5A5_A5A5), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, '0, 1'b0);
            en_cnt += int'(ifc.data_sram_en);
        end
        step(1'b0, 32'h0, '0, 1'b1);
        en_cnt += int'(ifc.data_sram_en);
        check("st_en", 64'(ifc.data_sram_en), 64'd1);
        check("st_we", 64'(ifc.data_sram_we), 64'hF);
        check("st_addr", 64'(ifc.data_sram_addr), 64'h1000);
        check("st_wdata", 64'(ifc.data_sram_wdata), 64'hA5A5_A5A5);
        step(1'b0, 32'h0, '0, 1'b1);
        en_cnt += int'(ifc.data_sram_en);
        check("st_once", 64'(en_cnt), 64'd1);

        // Divide finishing under MEM back-pressure holds its result
        step(1'b1, 32'h400, mk_div(32'd1000, 32'd7, 1'b0, 1'b0), 1'b0);
        for (int i = 0; i < 33; i++) step(1'b0, 32'h0, '0, 1'b0);
        check("hold_pre", 64'(ifc.EX_MEM_valid), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, '0, 1'b0);
            check("hold_mv", 64'(ifc.EX_MEM_valid), 64'd1);
            check("hold_allowin", 64'(ifc.EX_allowin), 64'd0);
            check("hold_res", 64'(ifc.EX_rf_bus[31:0]), 64'd142);
        end
        step(1'b0, 32'h0, '0, 1'b1);
        check("hold_release", 64'(ifc.EX_allowin), 64'd1);
        step(1'b0, 32'h0, '0, 1'b1);
        check("hold_gone", 64'(ifc.EX_MEM_valid), 64'd0);

        // Reset in the middle of a divide, then a fresh divide runs full length
        step(1'b1, 32'h500, mk_div(32'd77, 32'd5, 1'b0, 1'b0), 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, '0, 1'b1);
        do_reset("mid");
        run_div(32'd9, 32'd3, 1'b0, 1'b0, lat, res);
        check("post_rst_lat", 64'(lat), 64'd33);
        check("post_rst_res", 64'(res), 64'd3);

        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 9) < 7), $urandom, rand_instr(), 1'($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 EX_allowin  out  1  EX can accept an instruction this cycle.
REQ-004 ID_EX_valid  in  1  ID presents a valid instruction.
REQ-005 ID_pc  in  32  PC of the ID instruction.
REQ-006 ID_ex_bus  in  111  {alu_op[3:0], src1[31:0], src2[31:0], div_en, div_signed, div_rem, mem_re, mem_we, rf_we, rf_waddr[4:0], st_data[31:0]}, MSB first.
REQ-007 MEM_allowin  in  1  MEM can accept an instruction.
REQ-008 EX_MEM_valid  out  1  valid instruction handed to MEM.
REQ-009 EX_pc  out  32  PC of the EX instruction.
REQ-010 EX_rf_bus  out  39  {mem_re, rf_we & EX_valid, rf_waddr[4:0], ex_result[31:0]}.
REQ-011 data_sram_en  out  1  data SRAM request strobe.
REQ-012 data_sram_we  out  4  byte write enables.
REQ-013 data_sram_addr  out  32  request address.
REQ-014 data_sram_wdata  out  32  store data.

Function
REQ-015 EX_allowin = ~EX_valid | (EX_ready_go & MEM_allowin); EX_MEM_valid = EX_valid & EX_ready_go.
REQ-016 When EX_allowin=1, EX_valid SHALL load ID_EX_valid, and ID_ex_bus/ID_pc SHALL be latched only if ID_EX_valid=1; when EX_allowin=0, all EX registers hold.
REQ-017 ALU op: 0 ADD, 1 SUB, 2 SLT (signed), 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLL, 9 SRL, 10 SRA (shift amount src2[4:0]), 11 pass src2; codes 12-15 give 0; add/sub wrap modulo 2^32.
REQ-018 ex_result SHALL be the divider result when div_en=1, else the ALU result.
REQ-019 Non-divide instructions: EX_ready_go=1; one-cycle stage latency.
REQ-020 Divider FSM states IDLE, BUSY, DONE; IDLE->BUSY on EX_valid & div_en, latching operands; BUSY runs exactly 32 iterations, one per cycle, then ->DONE; DONE->IDLE when EX_allowin=1.
REQ-021 Divide instruction: EX_ready_go=1 only in DONE; an instruction arriving in cycle 0 is offered to MEM in cycle 33; DONE holds its result while MEM_allowin=0.
REQ-022 div_rem=0 selects quotient, div_rem=1 the remainder; signed mode: quotient truncates toward zero, remainder takes dividend sign.
REQ-023 Divisor 0: quotient 0xFFFFFFFF, remainder = dividend (both modes); 0x80000000 / -1 signed: quotient 0x80000000, remainder 0.
REQ-024 data_sram_en = EX_valid & EX_ready_go & MEM_allowin & (mem_re | mem_we); exactly one request per instruction, issued in its handoff cycle.
REQ-025 data_sram_we = {4{mem_we & data_sram_en}}; data_sram_addr = ALU result; data_sram_wdata = st_data.
REQ-026 mem_re and mem_we SHALL never be combined with div_en; ID guarantees this and EX does not check.

Reset
REQ-027 On reset: EX_valid=0, FSM=IDLE, iteration counter=0, EX_pc=0, latched bus=0; hence EX_MEM_valid=0, data_sram_en=0, data_sram_we=0, EX_rf_bus=0.
REQ-028 Reset asserted mid-divide SHALL abandon the operation; the first instruction after release starts from IDLE.

Structure
REQ-029 Shared package holds ALU op codes, divider state encodings, and bus widths (111, 39).
REQ-030 Iterative divider SHALL be sub-module ex_divider (start, signed, dividend, divisor -> busy, done, quotient, remainder); ALU is inline in ex_stage.

Verification
REQ-031 ADD 0x7FFFFFFF+1, MEM_allowin=1 -> next cycle EX_rf_bus[31:0]=0x80000000, EX_MEM_valid=1 for one cycle.
REQ-032 Signed DIV -7/2, quotient -> EX_MEM_valid first high 33 cycles after entry, result 0xFFFFFFFD; with div_rem=1 result 0xFFFFFFFF.
REQ-033 Unsigned DIV 100/0 -> quotient 0xFFFFFFFF; remainder 100.
REQ-034 Store addr 0x1000, data 0xA5A5A5A5, MEM_allowin low 3 cycles -> data_sram_en/we=0xF asserted exactly once, on the cycle MEM_allowin rises.
REQ-035 Divide completes while MEM_allowin=0 for 5 cycles -> FSM stays DONE, result stable, EX_allowin=0, handoff on release.
REQ-036 Reset asserted at iteration 10 of a divide -> all outputs 0 immediately; next divide 9/3 returns 3 with full 33-cycle latency.
